// File: rtl/rgb_sweep_ctrl.sv
// rgb_sweep_ctrl: sweeps all 16 {a,b} operand pairs through an external RGB unit,
// storing each {r,g,b_out} result in a readable table and counting the high bits.
module rgb_sweep_ctrl #(
   parameter int SETTLE_CYC = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       abort,
   output logic [1:0] rgb_a,
   output logic [1:0] rgb_b,
   input  logic       rgb_r,
   input  logic       rgb_g,
   input  logic       rgb_bo,
   output logic       busy,
   output logic       done,
   input  logic [3:0] rd_addr,
   output logic [2:0] rd_data,
   output logic [4:0] r_cnt,
   output logic [4:0] g_cnt,
   output logic [4:0] b_cnt
);
   typedef enum logic [2:0] {IDLE, DRIVE, SETTLE, CAPTURE, DONE} state_t;
   localparam logic [3:0] WAIT_LAST = 4'(SETTLE_CYC > 0 ? SETTLE_CYC - 1 : 0);
   state_t     state, state_nx;
   logic [3:0] idx, idx_nx, wait_cnt;
   logic [2:0] tab [16];
   logic       clr, wr, run_nx;
   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else state <= state_nx;
   end
   // next state, next vector index and table clear/write strobes; abort always beats the capture write
   always_comb begin
      state_nx = state;
      idx_nx = idx;
      clr = 1'b0;
      wr = 1'b0;
      case (state)
         IDLE: if (start && !abort) begin
            state_nx = DRIVE;
            idx_nx = 4'd0;
            clr = 1'b1;
         end
         DRIVE: state_nx = abort ? IDLE : (SETTLE_CYC > 0 ? SETTLE : CAPTURE);
         SETTLE: state_nx = abort ? IDLE : (wait_cnt == WAIT_LAST ? CAPTURE : SETTLE);
         CAPTURE: if (abort) state_nx = IDLE;
         else begin
            wr = 1'b1;
            state_nx = (idx == 4'hf) ? DONE : DRIVE;
            idx_nx = (idx == 4'hf) ? idx : idx + 4'd1;
         end
         default: state_nx = IDLE;
      endcase
   end
   assign run_nx = state_nx inside {DRIVE, SETTLE, CAPTURE};
   // index, settle wait counter and registered operands (held from DRIVE through CAPTURE, zero otherwise)
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx <= '0;
         wait_cnt <= '0;
         rgb_a <= '0;
         rgb_b <= '0;
      end else begin
         idx <= idx_nx;
         wait_cnt <= (state == SETTLE && state_nx == SETTLE) ? wait_cnt + 4'd1 : 4'd0;
         rgb_a <= run_nx ? idx_nx[3:2] : 2'd0;
         rgb_b <= run_nx ? idx_nx[1:0] : 2'd0;
      end
   end
   // result table and bit counters; counters saturate at 16 (bit 4 set) so they can never wrap
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n || clr) begin
         for (int i = 0; i < 16; i++) tab[i] <= '0;
         r_cnt <= '0;
         g_cnt <= '0;
         b_cnt <= '0;
      end else if (wr) begin
         tab[idx] <= {rgb_r, rgb_g, rgb_bo};
         r_cnt <= r_cnt + {4'd0, rgb_r & ~r_cnt[4]};
         g_cnt <= g_cnt + {4'd0, rgb_g & ~g_cnt[4]};
         b_cnt <= b_cnt + {4'd0, rgb_bo & ~b_cnt[4]};
      end
   end
   assign busy = state inside {DRIVE, SETTLE, CAPTURE};
   assign done = (state == DONE);
   assign rd_data = tab[rd_addr];
endmodule

// File: tb/tb_rgb_sweep_ctrl.sv
// tb_rgb_sweep_ctrl: directed + randomized checks of rgb_sweep_ctrl against a table/arithmetic model
module tb_rgb_sweep_ctrl;
   logic       clk = 1'b0;
   logic       rst_n, start, start0, abort;
   logic [3:0] rd_addr;
   logic [1:0] rgb_a, rgb_b, rgb_a0, rgb_b0;
   logic       busy, done, busy0, done0;
   logic [2:0] rd_data, rd_data0, resp, resp0;
   logic [4:0] r_cnt, g_cnt, b_cnt, r_cnt0, g_cnt0, b_cnt0;
   logic [2:0] lut [16];
   logic [3:0] ops_q = '0, ops0_q = '0;
   int         st = 0, st0 = 0;
   int         nchk = 0, nerr = 0;

   always #50 clk = ~clk;

   rgb_sweep_ctrl #(.SETTLE_CYC(2)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .rgb_a(rgb_a), .rgb_b(rgb_b), .rgb_r(resp[2]), .rgb_g(resp[1]), .rgb_bo(resp[0]),
      .busy(busy), .done(done), .rd_addr(rd_addr), .rd_data(rd_data),
      .r_cnt(r_cnt), .g_cnt(g_cnt), .b_cnt(b_cnt));

   rgb_sweep_ctrl #(.SETTLE_CYC(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .start(start0), .abort(1'b0),
      .rgb_a(rgb_a0), .rgb_b(rgb_b0), .rgb_r(resp0[2]), .rgb_g(resp0[1]), .rgb_bo(resp0[0]),
      .busy(busy0), .done(done0), .rd_addr(rd_addr), .rd_data(rd_data0),
      .r_cnt(r_cnt0), .g_cnt(g_cnt0), .b_cnt(b_cnt0));

   // RGB unit model: result is only valid once the operands have been stable long enough
   always @(posedge clk) begin
      st <= ({rgb_a, rgb_b} != ops_q) ? 0 : st + 1;
      ops_q <= {rgb_a, rgb_b};
      st0 <= ({rgb_a0, rgb_b0} != ops0_q) ? 0 : st0 + 1;
      ops0_q <= {rgb_a0, rgb_b0};
   end
   assign resp = (st >= 2) ? lut[{rgb_a, rgb_b}] : ~lut[{rgb_a, rgb_b}];
   assign resp0 = lut[{rgb_a0, rgb_b0}];

   function automatic logic [2:0] cmp_val(input int a);
      logic [3:0] v;
      v = 4'(a);
      return {v[3:2] > v[1:0], v[3:2] == v[1:0], v[3:2] < v[1:0]};
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nchk++;
      assert (got === exp) else begin
         nerr++;
         $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
      end
   endtask

   task automatic check_idle(input bit z, input string tag);
      chk({tag, " busy"}, 32'(z ? busy0 : busy), 0);
      chk({tag, " done"}, 32'(z ? done0 : done), 0);
      chk({tag, " rgb_a"}, 32'(z ? rgb_a0 : rgb_a), 0);
      chk({tag, " rgb_b"}, 32'(z ? rgb_b0 : rgb_b), 0);
   endtask

   // first n vectors captured from lut, the rest cleared; counts are popcounts over those entries
   task automatic check_tab(input bit z, input int n, input string tag);
      int er, eg, eb;
      logic [2:0] e;
      er = 0; eg = 0; eb = 0;
      for (int a = 0; a < 16; a++) begin
         e = (a < n) ? lut[a] : 3'b000;
         rd_addr = 4'(a);
         #1;
         chk($sformatf("%s z%0d rd_data[%0d]", tag, z, a), 32'(z ? rd_data0 : rd_data), 32'(e));
         er += int'(e[2]);
         eg += int'(e[1]);
         eb += int'(e[0]);
      end
      chk($sformatf("%s z%0d r_cnt", tag, z), 32'(z ? r_cnt0 : r_cnt), er);
      chk($sformatf("%s z%0d g_cnt", tag, z), 32'(z ? g_cnt0 : g_cnt), eg);
      chk($sformatf("%s z%0d b_cnt", tag, z), 32'(z ? b_cnt0 : b_cnt), eb);
   endtask

   // one sweep: ab = edge sampling abort, rs = edge before which reset is asserted,
   // rp = edge sampling a stray start pulse (-1 = unused); edges counted from the start edge
   task automatic sweep(input bit z, input int ab, input int rs, input int rp, input string tag);
      int len, d, first, width, bad_busy, nvec, lim;
      len = z ? 2 : 4;
      d = 16 * len;
      first = -1;
      width = 0;
      bad_busy = 0;
      lim = (ab > 0) ? ab : ((rs > 0) ? rs : d);
      nvec = (ab > 0) ? (ab - 1) / len : ((rs > 0) ? 0 : 16);
      @(negedge clk);
      if (z) start0 = 1'b1; else start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      start0 = 1'b0;
      for (int k = 1; k <= d + 6; k++) begin
         @(negedge clk);
         abort = (k == ab) && !z;
         if (z) start0 = (k == rp); else start = (k == rp);
         if (k == rs) begin
            rst_n = 1'b0;
            #1;
            check_idle(0, {tag, " async_rst"});
            rd_addr = 4'd0;
            #1;
            chk({tag, " async_rst rd_data[0]"}, 32'(rd_data), 0);
            chk({tag, " async_rst cnt_sum"}, 32'(r_cnt) + 32'(g_cnt) + 32'(b_cnt), 0);
         end
         @(posedge clk);
         #1;
         abort = 1'b0;
         start = 1'b0;
         start0 = 1'b0;
         if (k == rs) rst_n = 1'b1;
         if (z ? done0 : done) begin
            width++;
            if (first < 0) first = k;
         end
         if ((z ? busy0 : busy) !== (k < lim)) bad_busy++;
      end
      chk({tag, " done_edge"}, first, (ab > 0 || rs > 0) ? -1 : d);
      chk({tag, " done_width"}, width, (ab > 0 || rs > 0) ? 0 : 1);
      chk({tag, " busy_bad_cycles"}, bad_busy, 0);
      check_tab(z, nvec, tag);
   endtask

   initial begin
      int ab;
      rst_n = 1'b0;
      start = 1'b0;
      start0 = 1'b0;
      abort = 1'b0;
      rd_addr = 4'd0;
      for (int a = 0; a < 16; a++) lut[a] = cmp_val(a);
      repeat (3) @(posedge clk);
      #1;
      check_idle(0, "in_reset");
      @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      check_idle(0, "idle");
      check_idle(1, "idle");
      check_tab(0, 0, "idle");
      check_tab(1, 0, "idle");
      sweep(0, -1, -1, -1, "cmp_s2");
      sweep(1, -1, -1, -1, "cmp_s0");
      @(negedge clk);
      start = 1'b1;
      abort = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      abort = 1'b0;
      check_idle(0, "start_abort");
      repeat (3) @(posedge clk);
      #1;
      check_idle(0, "start_abort_later");
      check_tab(0, 16, "start_abort");
      sweep(0, 23, -1, -1, "abort_idx5");
      sweep(0, -1, -1, 30, "restart_mid");
      sweep(0, -1, -1, 65, "start_in_done");
      sweep(0, -1, 38, -1, "rst_idx9");
      sweep(0, -1, -1, -1, "after_rst");
      for (int it = 0; it < 4; it++) begin
         for (int a = 0; a < 16; a++) lut[a] = 3'($urandom);
         ab = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 64)) : -1;
         sweep(0, ab, -1, -1, $sformatf("rand%0d_s2", it));
         sweep(1, -1, -1, -1, $sformatf("rand%0d_s0", it));
      end
      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end
endmodule
